// File: rtl/carry_look_ahead_adder_core_if.sv
// Operand/result bundle for carry_look_ahead_adder_core.
// V exists only when CLA_OVERFLOW_EN is defined.
interface carry_look_ahead_adder_core_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef CLA_OVERFLOW_EN
    logic             V;
`endif

    modport master (
        output A,
        output B,
        output Cin,
        input  S,
        input  Cout
`ifdef CLA_OVERFLOW_EN
        ,
        input  V
`endif
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output S,
        output Cout
`ifdef CLA_OVERFLOW_EN
        ,
        output V
`endif
    );
endinterface

// File: rtl/carry_look_ahead_adder_core.sv
// Two-level carry-lookahead adder (4-bit groups plus a group lookahead unit) with a registered sum.
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output V.
module carry_look_ahead_adder_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    carry_look_ahead_adder_core_if.slave bus
);
    localparam int unsigned NG = WIDTH / 4;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
            $error("carry_look_ahead_adder_core: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
`ifdef CLA_OVERFLOW_EN
    logic             v_d, v_q;
`endif

    always_comb begin
        p = bus.A ^ bus.B;
        g = bus.A & bus.B;
    end

    always_comb begin
        gg = '0;
        gp = '0;
        for (int unsigned j = 0; j < NG; j++) begin
            gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
    end

    // Each group carry is an independent sum of products over GG/GP/Cin;
    // the inner loops only build AND terms, so nothing chains group to group.
    always_comb begin
        logic term;
        logic acc;
        gc   = '0;
        term = 1'b0;
        acc  = 1'b0;
        for (int unsigned j = 0; j <= NG; j++) begin
            term = bus.Cin;
            for (int unsigned k = 0; k < j; k++) begin
                term = term & gp[k];
            end
            acc = term;
            for (int unsigned k = 0; k < j; k++) begin
                term = gg[k];
                for (int unsigned m = k + 1; m < j; m++) begin
                    term = term & gp[m];
                end
                acc = acc | term;
            end
            gc[j] = acc;
        end
    end

    always_comb begin
        logic [3:0] gp4;
        logic [3:0] gg4;
        logic       ci;
        c   = '0;
        gp4 = '0;
        gg4 = '0;
        ci  = 1'b0;
        for (int unsigned j = 0; j < NG; j++) begin
            gp4 = p[4*j +: 4];
            gg4 = g[4*j +: 4];
            ci  = gc[j];
            c[4*j]   = ci;
            c[4*j+1] = gg4[0] | (gp4[0] & ci);
            c[4*j+2] = gg4[1] | (gp4[1] & gg4[0]) | (gp4[1] & gp4[0] & ci);
            c[4*j+3] = gg4[2] | (gp4[2] & gg4[1]) | (gp4[2] & gp4[1] & gg4[0])
                     | (gp4[2] & gp4[1] & gp4[0] & ci);
        end
    end

    always_comb begin
        s_d    = p ^ c;
        cout_d = gc[NG];
`ifdef CLA_OVERFLOW_EN
        v_d    = c[WIDTH-1] ^ gc[NG];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            v_q    <= 1'b0;
`endif
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
`ifdef CLA_OVERFLOW_EN
            v_q    <= v_d;
`endif
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
`ifdef CLA_OVERFLOW_EN
    assign bus.V    = v_q;
`endif
endmodule

// File: tb/tb_carry_look_ahead_adder_core.sv
// Directed and randomised checks of carry_look_ahead_adder_core at WIDTH=4 and WIDTH=16.
module tb_carry_look_ahead_adder_core;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    carry_look_ahead_adder_core_if #(.WIDTH(4))  if4 ();
    carry_look_ahead_adder_core_if #(.WIDTH(16)) if16 ();

    carry_look_ahead_adder_core #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    carry_look_ahead_adder_core #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        if4.A   = a;
        if4.B   = b;
        if4.Cin = cin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({if4.Cout, if4.S} !== 5'b0) begin
            bad++;
            $display("FAIL reset4: got Cout=%b S=%b exp Cout=0 S=0000", if4.Cout, if4.S);
        end
        total++;
        if ({if16.Cout, if16.S} !== 17'b0) begin
            bad++;
            $display("FAIL reset16: got Cout=%b S=%h exp Cout=0 S=0000", if16.Cout, if16.S);
        end
`ifdef CLA_OVERFLOW_EN
        total++;
        if (if4.V !== 1'b0) begin
            bad++;
            $display("FAIL reset_v: got V=%b exp V=0", if4.V);
        end
`endif
        drive4(4'b0011, 4'b0100, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== {1'b0, 4'b0111}) begin
            bad++;
            $display("FAIL first_edge: got Cout=%b S=%b exp Cout=0 S=0111", if4.Cout, if4.S);
        end
    endtask

    task automatic test_doubling();
        logic [3:0] k4;
        logic [3:0] exp_s;
        logic       exp_c;
        for (int k = 0; k < 16; k++) begin
            k4 = 4'(k);
            drive4(k4, k4, 1'b0);
            @(posedge clk);
            #1;
            exp_s = 4'((2 * k) % 16);
            exp_c = (k >= 8);
            total++;
            if ({if4.Cout, if4.S} !== {exp_c, exp_s}) begin
                bad++;
                $display("FAIL doubling k=%0d: got Cout=%b S=%b exp Cout=%b S=%b",
                         k, if4.Cout, if4.S, exp_c, exp_s);
            end
        end
    endtask

    task automatic test_full_propagate();
        drive4(4'b1111, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== {1'b1, 4'b0000}) begin
            bad++;
            $display("FAIL propagate_cin1: got Cout=%b S=%b exp Cout=1 S=0000", if4.Cout, if4.S);
        end
        drive4(4'b1111, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== {1'b0, 4'b1111}) begin
            bad++;
            $display("FAIL propagate_cin0: got Cout=%b S=%b exp Cout=0 S=1111", if4.Cout, if4.S);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta [5] = '{4'd9,  4'd6, 4'd10, 4'd4,  4'd14};
        logic [3:0] tb [5] = '{4'd8,  4'd9, 4'd3,  4'd12, 4'd1};
        logic       tc [5] = '{1'b0,  1'b1, 1'b0,  1'b1,  1'b0};
        logic [3:0] es [5] = '{4'h1,  4'h0, 4'hD,  4'h1,  4'hF};
        logic       ec [5] = '{1'b1,  1'b1, 1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 5; i++) begin
            drive4(ta[i], tb[i], tc[i]);
            @(posedge clk);
            #1;
            total++;
            if ({if4.Cout, if4.S} !== {ec[i], es[i]}) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got Cout=%b S=%h exp Cout=%b S=%h",
                         i, if4.Cout, if4.S, ec[i], es[i]);
            end
        end
    endtask

    task automatic test_stability();
        drive4(4'd5, 4'd6, 1'b0);
        @(posedge clk);
        #1;
        drive4(4'hF, 4'hF, 1'b1);
        #3;
        total++;
        if ({if4.Cout, if4.S} !== {1'b0, 4'b1011}) begin
            bad++;
            $display("FAIL stability_hold: got Cout=%b S=%b exp Cout=0 S=1011", if4.Cout, if4.S);
        end
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== {1'b1, 4'b1111}) begin
            bad++;
            $display("FAIL stability_next: got Cout=%b S=%b exp Cout=1 S=1111", if4.Cout, if4.S);
        end
    endtask

`ifdef CLA_OVERFLOW_EN
    task automatic test_overflow();
        drive4(4'b0111, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if ({if4.V, if4.Cout, if4.S} !== {1'b1, 1'b0, 4'b1000}) begin
            bad++;
            $display("FAIL ovf_pos: got V=%b Cout=%b S=%b exp V=1 Cout=0 S=1000", if4.V, if4.Cout, if4.S);
        end
        drive4(4'b1000, 4'b1000, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if ({if4.V, if4.Cout, if4.S} !== {1'b1, 1'b1, 4'b0000}) begin
            bad++;
            $display("FAIL ovf_neg: got V=%b Cout=%b S=%b exp V=1 Cout=1 S=0000", if4.V, if4.Cout, if4.S);
        end
        drive4(4'b0011, 4'b0100, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if ({if4.V, if4.Cout, if4.S} !== {1'b0, 1'b0, 4'b0111}) begin
            bad++;
            $display("FAIL ovf_none: got V=%b Cout=%b S=%b exp V=0 Cout=0 S=0111", if4.V, if4.Cout, if4.S);
        end
    endtask
`endif

    task automatic test_midstream_reset();
        drive4(4'b0001, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== {1'b0, 4'b0010}) begin
            bad++;
            $display("FAIL pre_reset: got Cout=%b S=%b exp Cout=0 S=0010", if4.Cout, if4.S);
        end
        drive4(4'b0101, 4'b0101, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if4.Cout, if4.S} !== 5'b0) begin
            bad++;
            $display("FAIL reset_immediate: got Cout=%b S=%b exp Cout=0 S=0000", if4.Cout, if4.S);
        end
`ifdef CLA_OVERFLOW_EN
        total++;
        if (if4.V !== 1'b0) begin
            bad++;
            $display("FAIL reset_immediate_v: got V=%b exp V=0", if4.V);
        end
`endif
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== 5'b0) begin
            bad++;
            $display("FAIL reset_held: got Cout=%b S=%b exp Cout=0 S=0000", if4.Cout, if4.S);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({if4.Cout, if4.S} !== {1'b0, 4'b1010}) begin
            bad++;
            $display("FAIL after_release: got Cout=%b S=%b exp Cout=0 S=1010", if4.Cout, if4.S);
        end
    endtask

    task automatic test_random16();
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] expv;
        int          nbad_before;
        if16.A   = 16'hFFFF;
        if16.B   = 16'h0000;
        if16.Cin = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({if16.Cout, if16.S} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL w16_propagate: got Cout=%b S=%h exp Cout=1 S=0000", if16.Cout, if16.S);
        end
        nbad_before = bad;
        for (int i = 0; i < 10000; i++) begin
            a   = 16'($urandom_range(0, 65535));
            b   = 16'($urandom_range(0, 65535));
            cin = 1'($urandom_range(0, 1));
            if16.A   = a;
            if16.B   = b;
            if16.Cin = cin;
            expv = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            @(posedge clk);
            #1;
            total++;
            if ({if16.Cout, if16.S} !== expv) begin
                bad++;
                if (bad - nbad_before <= 10)
                    $display("FAIL w16_random[%0d] %h+%h+%b: got Cout=%b S=%h exp Cout=%b S=%h",
                             i, a, b, cin, if16.Cout, if16.S, expv[16], expv[15:0]);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        if4.A    = '0;
        if4.B    = '0;
        if4.Cin  = 1'b0;
        if16.A   = '0;
        if16.B   = '0;
        if16.Cin = 1'b0;
        #2;
        test_reset();
        test_doubling();
        test_full_propagate();
        test_back_to_back();
        test_stability();
`ifdef CLA_OVERFLOW_EN
        test_overflow();
`endif
        test_midstream_reset();
        test_random16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
